// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions: ALU operation encodings plus the program loader's
// state type and stream-format constants.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the CHECK state used
// for the trailing checksum byte of the program stream.
// -----------------------------------------------------------------------------
package cpu_pkg;

    // ALU operation encodings used by the execute stage.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    // The program stream starts with a little-endian word count of this many bytes.
    localparam int LOADER_HDR_BYTES = 2;
    localparam int LOADER_CNT_BITS  = 8 * LOADER_HDR_BYTES;

    // Program loader states. CHECK only exists when the checksum is enabled.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_LO = 3'd1,
        HDR_HI = 3'd2,
        DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK  = 3'd4,
`endif
        DONE   = 3'd5,
        ERROR  = 3'd6
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Receives a program as a byte stream (valid/ready) and writes it word by word
// into instruction memory while holding the CPU in reset.
//
// Stream: 16-bit word count N (low byte first), then N words of 4 bytes,
// least-significant byte first. With IMEM_LOADER_CHECKSUM_EN defined, one
// trailing byte equal to the XOR of all header and data bytes follows.
//
// Parameters:
//   DEPTH_WORDS - maximum program length in words (longer headers -> error)
//   BASE_ADDR   - byte address of the first instruction word
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   start                - one-cycle load request (honoured in IDLE/DONE/ERROR)
//   byte_valid/byte_data - incoming stream byte
//   byte_ready           - loader accepts a byte this cycle
//   wr_en/wr_addr/wr_data- instruction-memory write port (one-cycle strobe)
//   cpu_hold             - holds the CPU in reset until the load is done
//   done / error         - load finished successfully / failed
// -----------------------------------------------------------------------------
module imem_loader
    import cpu_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_DATA = CHECK;
`else
    localparam loader_state_t AFTER_DATA = DONE;
`endif

    loader_state_t              state_reg;
    loader_state_t              state_next;
    logic [LOADER_CNT_BITS-1:0] word_count_reg;
    logic [LOADER_CNT_BITS-1:0] word_idx_reg;
    logic [1:0]                 byte_idx_reg;
    logic [23:0]                shift_reg;      // first three bytes of the current word
    logic                       wr_en_reg;
    logic [31:0]                wr_addr_reg;
    logic [31:0]                wr_data_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]                 csum_reg;
`endif

    logic                       accept;
    logic                       load_start;
    logic [LOADER_CNT_BITS-1:0] hdr_count;
    logic                       last_write;

    assign accept     = byte_valid & byte_ready;
    // Full word count as it becomes known on the high header byte.
    assign hdr_count  = {byte_data, word_count_reg[7:0]};
    // word_idx_reg is bumped together with the write strobe, so during the
    // write cycle it already counts the word being written.
    assign last_write = wr_en_reg && (word_idx_reg == word_count_reg);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        byte_ready = 1'b0;
        load_start = 1'b0;
        case (state_reg)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    load_start = 1'b1;
                    state_next = HDR_LO;
                end
            end
            HDR_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_next = HDR_HI;
                end
            end
            HDR_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    if ({16'd0, hdr_count} > DEPTH_LIMIT) begin
                        state_next = ERROR;
                    end else if (hdr_count == '0) begin
                        state_next = AFTER_DATA;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                // Stall the stream while a word is being written out.
                byte_ready = !wr_en_reg;
                if (last_write) begin
                    state_next = AFTER_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_next = (byte_data == csum_reg) ? DONE : ERROR;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_count_reg <= '0;
            word_idx_reg   <= '0;
            byte_idx_reg   <= 2'd0;
            shift_reg      <= 24'd0;
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= 32'd0;
            wr_data_reg    <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg       <= 8'd0;
`endif
        end else begin
            wr_en_reg <= 1'b0;

            if (load_start) begin
                word_idx_reg <= '0;
                byte_idx_reg <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_reg     <= 8'd0;
`endif
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            if (accept) begin
                csum_reg <= csum_reg ^ byte_data;
            end
`endif

            if (accept && state_reg == HDR_LO) begin
                word_count_reg[7:0] <= byte_data;
            end
            if (accept && state_reg == HDR_HI) begin
                word_count_reg[15:8] <= byte_data;
            end

            if (accept && state_reg == DATA) begin
                byte_idx_reg <= byte_idx_reg + 2'd1;
                shift_reg    <= {byte_data, shift_reg[23:8]};
                if (byte_idx_reg == 2'd3) begin
                    wr_en_reg    <= 1'b1;
                    wr_addr_reg  <= BASE_ADDR + {14'd0, word_idx_reg, 2'b00};
                    wr_data_reg  <= {byte_data, shift_reg};
                    word_idx_reg <= word_idx_reg + 1'b1;
                end
            end
        end
    end

    assign wr_en    = wr_en_reg;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;
    assign cpu_hold = (state_reg != DONE);
    assign done     = (state_reg == DONE);
    assign error    = (state_reg == ERROR);

endmodule
